obstacle_lane_engine: RTL

- Parametrised successor to the fixed 3-digit obstacle generator/collision pair of the keypad hero game.
- Scrolls a configurable-length lane of obstacle glyphs toward the hero digit, checks collisions, and keeps score and lives.
- Drives W_or_L for the top-level FSM.
- Sits between the hero ROM/chooser, the obstacle ROM and the display mux.

---
 rtl/obstacle_lane_engine.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/obstacle_lane_engine.sv
// obstacle_lane_engine: scrolls an N_POS-slot obstacle lane toward the hero digit,
// scores cleared obstacles, tracks lives and reports win/lose. Optional macro: OBS_SPEEDUP_EN.
module obstacle_lane_engine #(
  parameter int unsigned N_POS     = 3,
  parameter int unsigned TICK_DIV  = 25000000,
  parameter int unsigned SCORE_W   = 8,
  parameter int unsigned WIN_SCORE = 20,
  parameter int unsigned LIVES     = 3,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [6:0]           hero,
  input  logic [6:0]           obstacle,
  output logic [3:0]           tipo_obs,
  output logic [7*N_POS-1:0]   display_obs,
  output logic [SCORE_W-1:0]   score,
  output logic [2:0]           lives,
  output logic [1:0]           W_or_L,
  output logic                 step_pulse
);
  localparam int unsigned        LANE_W    = 7 * N_POS;
  localparam int unsigned        CNT_W     = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]   DIV_M1    = CNT_W'(TICK_DIV - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] WIN_S     = SCORE_W'(WIN_SCORE);
  localparam logic [2:0]         LIVES_S   = 3'(LIVES);
  localparam logic [7:0]         LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {S_IDLE, S_PLAY, S_HIT, S_WIN, S_LOSE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, div_q, div_d;
  logic [LANE_W-1:0]   lane_q, lane_d, disp_q, disp_d, shifted_s;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [2:0]          lives_q, lives_d;
  logic [7:0]          lfsr_q, lfsr_d, lfsr_adv_s;
  logic [1:0]          wl_q, wl_d;
  logic [6:0]          top_s;
  logic                step_q, step_s, hit_s, spawn_s, restart_s;

`ifdef OBS_SPEEDUP_EN
  // Scroll period shrinks by TICK_DIV/8 for every 8 points, never below TICK_DIV/4.
  function automatic logic [CNT_W-1:0] div_m1_for(input logic [SCORE_W-1:0] s);
    int unsigned red;
    int unsigned eff;
    red = (TICK_DIV / 8) * (32'(s) >> 3);
    if (red > TICK_DIV - TICK_DIV / 4) eff = TICK_DIV / 4;
    else eff = TICK_DIV - red;
    return CNT_W'(eff - 1);
  endfunction
`endif

  // Next-state: tick counter, lane scroll, collision/score, lives and game state.
  always_comb begin
    step_s     = ((state_q == S_PLAY) || (state_q == S_HIT)) && (cnt_q == div_q);
    restart_s  = start && ((state_q == S_IDLE) || (state_q == S_WIN) || (state_q == S_LOSE));
    hit_s      = |(lane_q[6:0] & hero);
    spawn_s    = (lfsr_q[7:6] != 2'b00) && (lane_q[LANE_W-1 -: 7] == 7'd0);
    lfsr_adv_s = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 8'h00);
    top_s      = spawn_s ? obstacle : 7'd0;
    shifted_s  = (lane_q >> 7) | (LANE_W'(top_s) << (7 * (N_POS - 1)));

    state_d = state_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    score_d = score_q;
    lives_d = lives_q;
    lfsr_d  = lfsr_q;

    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        cnt_d = '0;
        if (restart_s) begin
          state_d = S_PLAY;
          lane_d  = '0;
          score_d = '0;
          lives_d = LIVES_S;
          lfsr_d  = LFSR_SEED;
        end else begin
          state_d = state_q;
        end
      end
      S_PLAY: begin
        if (step_s) begin
          cnt_d  = '0;
          lane_d = shifted_s;
          lfsr_d = lfsr_adv_s;
          if (hit_s) begin
            lives_d = lives_q - 3'd1;
            state_d = (lives_q == 3'd1) ? S_LOSE : S_HIT;
          end else if (lane_q[6:0] != 7'd0) begin
            score_d = (score_q == SCORE_MAX) ? score_q : score_q + SCORE_W'(1);
            state_d = (score_d == WIN_S) ? S_WIN : S_PLAY;
          end else begin
            state_d = S_PLAY;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HIT: begin
        if (step_s) begin
          cnt_d   = '0;
          state_d = S_PLAY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

`ifdef OBS_SPEEDUP_EN
    if (restart_s) div_d = DIV_M1;
    else if (step_s) div_d = div_m1_for(score_d);
    else div_d = div_q;
`else
    div_d = DIV_M1;
`endif

    disp_d = (state_d == S_HIT) ? '0 : lane_d;
    case (state_d)
      S_WIN:   wl_d = 2'b01;
      S_LOSE:  wl_d = 2'b10;
      default: wl_d = 2'b00;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= DIV_M1;
      lane_q  <= '0;
      disp_q  <= '0;
      score_q <= '0;
      lives_q <= LIVES_S;
      lfsr_q  <= LFSR_SEED;
      wl_q    <= 2'b00;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      lane_q  <= lane_d;
      disp_q  <= disp_d;
      score_q <= score_d;
      lives_q <= lives_d;
      lfsr_q  <= lfsr_d;
      wl_q    <= wl_d;
      step_q  <= step_s;
    end
  end

  assign tipo_obs    = lfsr_q[3:0];
  assign display_obs = disp_q;
  assign score       = score_q;
  assign lives       = lives_q;
  assign W_or_L      = wl_q;
  assign step_pulse  = step_q;

endmodule
